// File: rtl/sockit_spi_pkg.sv
// Shared SPI definitions: IO modes, control-field positions and the lane-split helper
// used when turning a command word into serializer beats.
package sockit_spi_pkg;

    localparam int unsigned SDW = 8;

    typedef enum logic [1:0] {
        IOM_3WR  = 2'd0,
        IOM_SPI  = 2'd1,
        IOM_DUAL = 2'd2,
        IOM_QUAD = 2'd3
    } iom_t;

    // Command control: [5] new, [4] lst, [3:2] cnt, [1:0] iom
    localparam int unsigned CMD_NEW    = 5;
    localparam int unsigned CMD_LST    = 4;
    localparam int unsigned CMD_CNT_HI = 3;
    localparam int unsigned CMD_CNT_LO = 2;
    localparam int unsigned CMD_IOM_HI = 1;
    localparam int unsigned CMD_IOM_LO = 0;

    // Queue control: [3] new, [2] lst, [1:0] iom
    localparam int unsigned QUE_NEW    = 3;
    localparam int unsigned QUE_LST    = 2;
    localparam int unsigned QUE_IOM_HI = 1;
    localparam int unsigned QUE_IOM_LO = 0;

    // Highest legal beat index (beats-1) for a given IO mode.
    function automatic logic [1:0] cnt_max(input logic [1:0] iom);
        logic [1:0] r;
        case (iom)
            IOM_3WR, IOM_SPI: r = 2'd3;
            IOM_DUAL:         r = 2'd1;
            default:          r = 2'd0;
        endcase
        return r;
    endfunction

    // Spread the top bits of a word over the IO lanes, MSB first; unused lanes stay 0.
    function automatic logic [4*SDW-1:0] upk(input logic [31:0] w, input logic [1:0] iom);
        logic [4*SDW-1:0] q;
        q = '0;
        case (iom)
            IOM_3WR, IOM_SPI: begin
                for (int i = 0; i < SDW; i++) begin
                    q[SDW-1-i] = w[31-i];
                end
            end
            IOM_DUAL: begin
                for (int i = 0; i < SDW; i++) begin
                    q[2*SDW-1-i] = w[31-2*i];
                    q[SDW-1-i]   = w[30-2*i];
                end
            end
            default: begin
                for (int i = 0; i < SDW; i++) begin
                    for (int k = 0; k < 4; k++) begin
                        q[(k+1)*SDW-1-i] = w[28+k-4*i];
                    end
                end
            end
        endcase
        return q;
    endfunction

endpackage

// File: rtl/sockit_spi_rpo.sv
// Output repackager: splits 32-bit command words into 1..4 serializer beats, distributing
// the bits across the SPI IO lanes according to the word's IO mode.
module sockit_spi_rpo
    import sockit_spi_pkg::*;
#(
    parameter int unsigned SDW = 8,
    parameter int unsigned CCI = 6,
    parameter int unsigned CDW = 32,
    parameter int unsigned QCO = 4,
    parameter int unsigned QDW = 4*SDW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cmd_req,
    input  logic [CCI-1:0] cmd_ctl,
    input  logic [CDW-1:0] cmd_dat,
    output logic           cmd_grt,
    output logic           que_req,
    output logic [QCO-1:0] que_ctl,
    output logic [QDW-1:0] que_dat,
    input  logic           que_grt
);

    logic           r_busy;
    logic [1:0]     r_cyc_cnt;
    logic [1:0]     r_cyc_max;
    logic [CDW-1:0] r_cyc_dat;
    logic           r_cyc_new;
    logic           r_cyc_lst;
    logic [1:0]     r_cyc_iom;

    logic           w_cmd_trn;
    logic           w_que_trn;
    logic           w_last;
    logic [1:0]     w_ld_iom;
    logic [1:0]     w_ld_cnt;
    logic [1:0]     w_ld_max;

    assign w_last    = (r_cyc_cnt == r_cyc_max);
    assign w_que_trn = que_req & que_grt;
    // Grant straight through on the last beat so back-to-back words leave no bubble.
    assign cmd_grt   = ~r_busy | (w_que_trn & w_last);
    assign w_cmd_trn = cmd_req & cmd_grt;

    assign w_ld_iom = cmd_ctl[CMD_IOM_HI:CMD_IOM_LO];
    assign w_ld_cnt = cmd_ctl[CMD_CNT_HI:CMD_CNT_LO];
    assign w_ld_max = (w_ld_cnt > cnt_max(w_ld_iom)) ? cnt_max(w_ld_iom) : w_ld_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy    <= 1'b0;
            r_cyc_cnt <= 2'd0;
            r_cyc_max <= 2'd0;
            r_cyc_new <= 1'b0;
            r_cyc_lst <= 1'b0;
            r_cyc_iom <= 2'd0;
        end else if (w_cmd_trn) begin
            r_busy    <= 1'b1;
            r_cyc_cnt <= 2'd0;
            r_cyc_max <= w_ld_max;
            r_cyc_new <= cmd_ctl[CMD_NEW];
            r_cyc_lst <= cmd_ctl[CMD_LST];
            r_cyc_iom <= w_ld_iom;
        end else if (w_que_trn) begin
            if (w_last) begin
                r_busy <= 1'b0;
            end else begin
                r_cyc_cnt <= r_cyc_cnt + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cyc_dat <= '0;
        end else if (w_cmd_trn) begin
            r_cyc_dat <= cmd_dat;
        end else if (w_que_trn && !w_last) begin
            r_cyc_dat <= (r_cyc_iom == IOM_DUAL) ? (r_cyc_dat << 16) : (r_cyc_dat << 8);
        end
    end

    // Outputs are gated by busy so an idle queue port reads all-zero.
    always_comb begin
        que_req = r_busy;
        que_ctl = '0;
        que_dat = '0;
        if (r_busy) begin
            que_ctl[QUE_NEW]               = r_cyc_new & (r_cyc_cnt == 2'd0);
            que_ctl[QUE_LST]               = r_cyc_lst & w_last;
            que_ctl[QUE_IOM_HI:QUE_IOM_LO] = r_cyc_iom;
            que_dat                        = upk(r_cyc_dat, r_cyc_iom);
        end
    end

endmodule
